// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load, hold stall and done pulse.
// Bit order is set by MSB_FIRST; a new word can follow the last bit with no gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  logic last;
  logic advance;
  logic accept;

  // cnt is the 1-based index of the bit currently on ser_out
  assign last    = (state == SHIFT) && (cnt == CW'(WIDTH));
  assign advance = (state == SHIFT) && !hold;
  assign accept  = load_valid && load_ready;

  assign load_ready = !rst && ((state == IDLE) || (last && !hold));

  assign busy      = (state == SHIFT);
  assign ser_valid = advance;
  assign done      = advance && last;
  assign ser_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= load_data;
      cnt   <= CW'(1);
    end else if (advance) begin
      if (last) begin
        // clearing sreg forces ser_out low in IDLE
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else begin
        if (MSB_FIRST) begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        end else begin
          sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB- and LSB-first instances share stimulus.
// Inputs change just after each rising edge; outputs are checked before the next.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load_data;
  logic       load_valid;
  logic       hold;

  logic m_ready, m_out, m_valid, m_busy, m_done;
  logic l_ready, l_out, l_valid, l_busy, l_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .rst        (rst),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .hold       (hold),
    .ser_out    (m_out),
    .ser_valid  (m_valid),
    .busy       (m_busy),
    .done       (m_done)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .rst        (rst),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .hold       (hold),
    .ser_out    (l_out),
    .ser_valid  (l_valid),
    .busy       (l_busy),
    .done       (l_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic h);
    load_valid = v;
    load_data  = d;
    hold       = h;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_out"}, m_out, 0);
    chk({tag, "_done"}, m_done, 0);
  endtask

  // one presented MSB-first bit on dut_m
  task automatic chk_bit(input string tag, input logic b, input logic dn);
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_out"}, m_out, b);
    chk({tag, "_done"}, m_done, dn);
  endtask

  initial begin
    logic [7:0] w;
    logic [15:0] ww;
    int n;

    rst = 1'b1;
    drive(1'b1, 8'hFF, 1'b1);
    chk("rst_ready", m_ready, 0);
    tick();
    tick();
    chk_idle("rst");
    chk("rst_sreg_out_l", l_out, 0);

    // first acceptance right after reset release, A5 MSB first
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("rel_ready", m_ready, 1);
    chk_idle("rel");
    drive(1'b1, 8'hA5, 1'b0);
    tick();
    w = 8'hA5;
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_bit($sformatf("a5_b%0d", i), w[7-i], i == 7);
      chk($sformatf("a5_busy%0d", i), m_busy, 1);
      tick();
    end
    chk_idle("a5_end");
    chk("a5_end_ready", m_ready, 1);

    // 0A LSB first on dut_l
    drive(1'b1, 8'h0A, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    w = 8'b0000_1010;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) chk($sformatf("0a_b%0d", i), l_out, w[i]);
      if (l_valid) n++;
      tick();
    end
    chk("0a_nvalid", n, 8);
    chk("0a_idle_out", l_out, 0);

    // back-to-back AA then 55
    ww = 16'b1010_1010_0101_0101;
    drive(1'b1, 8'hAA, 1'b0);
    tick();
    for (int i = 1; i <= 16; i++) begin
      drive(i < 16, 8'h55, 1'b0);
      chk_bit($sformatf("b2b_b%0d", i), ww[16-i], (i == 8) || (i == 16));
      chk($sformatf("b2b_rdy%0d", i), m_ready, (i == 8) || (i == 16));
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_idle("b2b_end");

    // F0 with 3 hold cycles after bit 2: done 11 cycles after accept
    w = 8'hF0;
    drive(1'b1, w, 1'b0);
    tick();
    n = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c >= 3 && c <= 5) begin
        drive(1'b0, 8'h00, 1'b1);
        chk($sformatf("f0_h%0d_valid", c), m_valid, 0);
        chk($sformatf("f0_h%0d_out", c), m_out, 1);
        chk($sformatf("f0_h%0d_done", c), m_done, 0);
        chk($sformatf("f0_h%0d_busy", c), m_busy, 1);
      end else begin
        drive(1'b0, 8'h00, 1'b0);
        chk_bit($sformatf("f0_c%0d", c), w[7-n], c == 11);
        n++;
      end
      tick();
    end
    chk_idle("f0_end");

    // hold during last bit; accepted in IDLE while hold is high
    w = 8'h01;
    drive(1'b1, w, 1'b1);
    chk("idle_hold_ready", m_ready, 1);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk_bit($sformatf("lh_b%0d", i), w[7-i], 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h3C, 1'b1);
      chk($sformatf("lh_h%0d_valid", i), m_valid, 0);
      chk($sformatf("lh_h%0d_done", i), m_done, 0);
      chk($sformatf("lh_h%0d_ready", i), m_ready, 0);
      chk($sformatf("lh_h%0d_out", i), m_out, 1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    chk_bit("lh_last", 1'b1, 1'b1);
    chk("lh_last_ready", m_ready, 1);
    tick();
    chk_idle("lh_end");

    // C3 aborted by reset after bit 4, then 81
    w = 8'hC3;
    drive(1'b1, w, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk_bit($sformatf("c3_b%0d", i), w[7-i], 0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 8'hFF, 1'b1);
    chk("c3_rst_ready", m_ready, 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h81, 1'b0);
    chk_idle("c3_abort");
    tick();
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk_bit($sformatf("81_b%0d", i), w[7-i], i == 7);
      tick();
    end
    chk_idle("81_end");

    // FF offered mid-word is ignored
    drive(1'b1, 8'h00, 1'b0);
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i == 2, 8'hFF, 1'b0);
      if (i == 2) chk("00_ign_ready", m_ready, 0);
      if (i < 8) chk_bit($sformatf("00_b%0d", i), 1'b0, i == 7);
      if (m_done) n++;
      tick();
    end
    chk("00_ndone", n, 1);
    chk_idle("00_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = LSB first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 load_data  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  load_data is valid this cycle.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 hold  input  1  stall request from downstream; freezes shifting.
REQ-009 ser_out  output  1  serial bit stream to the downstream serial sequence detector input.
REQ-010 ser_valid  output  1  ser_out carries a new bit this cycle.
REQ-011 busy  output  1  a word is in progress (state SHIFT).
REQ-012 done  output  1  single-cycle pulse coincident with the last bit of a word.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 A word SHALL be accepted at a rising edge where load_valid=1 and load_ready=1; load_data is captured into an internal shift register.
REQ-015 load_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when the current bit is the last bit and hold=0; 0 otherwise; 0 while rst=1.
REQ-016 Latency: the first bit of an accepted word SHALL appear on ser_out with ser_valid=1 in the cycle immediately after the accepting edge.
REQ-017 In SHIFT with hold=0, each cycle SHALL present one bit with ser_valid=1; WIDTH bits total per word, order set by MSB_FIRST.
REQ-018 A bit counter of width clog2(WIDTH)+1 SHALL count presented bits; it SHALL not wrap within a word.
REQ-019 In SHIFT with hold=1, ser_valid SHALL be 0, ser_out SHALL hold its previous value, and the shift register and counter SHALL not advance.
REQ-020 hold asserted during the last bit SHALL extend that bit: ser_valid=0, done=0, load_ready=0 until hold deasserts, after which the last bit is presented with ser_valid=1 and done=1.
REQ-021 done SHALL be 1 exactly in the cycle the WIDTH-th bit is presented with ser_valid=1, else 0.
REQ-022 After the last bit, if no word is accepted, FSM SHALL return to IDLE next cycle; ser_out=0, ser_valid=0 in IDLE.
REQ-023 Back-to-back: if a word is accepted at the edge ending the last bit, FSM SHALL remain in SHIFT and the new word's first bit SHALL follow with no gap cycle.
REQ-024 load_valid while load_ready=0 SHALL be ignored; load_data SHALL not be sampled.
REQ-025 hold in IDLE SHALL have no effect; load acceptance in IDLE is independent of hold.
REQ-026 busy SHALL equal (state == SHIFT).

Reset
REQ-027 With rst=1 at a rising edge: state=IDLE, shift register=0, counter=0, ser_out=0, ser_valid=0, done=0, busy=0.
REQ-028 rst SHALL override load_valid and hold in the same cycle; a word in progress SHALL be discarded with no done pulse.
REQ-029 First acceptance SHALL be possible at the first edge after rst deasserts.

Verification
REQ-030 Reset then load 8'hA5 (MSB_FIRST=1), hold=0 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept, done=1 on 8th, then IDLE.
REQ-031 MSB_FIRST=0, load 8'h0A -> ser_out 0,1,0,1,0,0,0,0; ser_valid high for exactly 8 cycles.
REQ-032 Back-to-back 8'hAA then 8'h55 with load_valid held high -> 16 contiguous valid bits 1010101001010101, done pulses on bits 8 and 16, load_ready high only on bits 8 and 16 during SHIFT.
REQ-033 Load 8'hF0, assert hold for 3 cycles after bit 2 -> ser_valid=0 for those 3 cycles, ser_out holds 1, remaining bits 1,1,0,0,0,0 resume; total 11 cycles accept-to-done.
REQ-034 Load 8'hC3, assert rst after bit 4 -> next cycle ser_valid=0, ser_out=0, busy=0, no done; new load 8'h81 afterwards serializes 1,0,0,0,0,0,0,1 correctly.
REQ-035 load_valid pulsed with 8'hFF during bit 3 of 8'h00 -> ignored; stream remains all zeros, single done pulse.
